// File: rtl/cisc_pkg.sv
// cisc_pkg: shared addressing-mode and fetch-state types plus default widths.
package cisc_pkg;
   localparam int RAM_ADDR_W = 8;
   localparam int RAM_DATA_W = 8;
   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 8;
   localparam int OPERAND_W  = 8;

   typedef enum logic [1:0] {
      IMM   = 2'b00,
      DIR   = 2'b01,
      INDIR = 2'b10,
      REG   = 2'b11
   } addr_mode_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REG_REQ  = 3'd1,
      REG_WAIT = 3'd2,
      RAM_REQ  = 3'd3,
      RAM_WAIT = 3'd4,
      DONE     = 3'd5
   } fetch_state_t;
endpackage

// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: multi-cycle operand fetch over sync-read register file and RAM.
// Define OPERAND_FETCH_AUTOINC_EN to post-increment the pointer register in INDIR mode.
module operand_fetch_ctrl
   import cisc_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = RAM_ADDR_W,
   parameter int RAM_DATA_WIDTH = RAM_DATA_W,
   parameter int REG_ADDR_WIDTH = REG_ADDR_W,
   parameter int REG_DATA_WIDTH = REG_DATA_W,
   parameter int OPERAND_WIDTH  = OPERAND_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [OPERAND_WIDTH-1:0]  operand_in,
   output logic                      busy,
   output logic                      valid,
   output logic [RAM_DATA_WIDTH-1:0] data_out,
   output logic                      reg_rd_en,
   output logic [REG_ADDR_WIDTH-1:0] reg_addr,
   input  logic [REG_DATA_WIDTH-1:0] reg_rd_data,
   output logic                      reg_wr_en,
   output logic [REG_DATA_WIDTH-1:0] reg_wr_data,
   output logic                      ram_rd_en,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data
);
   fetch_state_t              state_q, state_d;
   addr_mode_t                mode_q, mode_d;
   logic [OPERAND_WIDTH-1:0]  operand_q, operand_d;
   logic [RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [RAM_DATA_WIDTH-1:0] data_q, data_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mode_q    <= IMM;
         operand_q <= '0;
         ptr_q     <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         operand_q <= operand_d;
         ptr_q     <= ptr_d;
         data_q    <= data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      operand_d   = operand_q;
      ptr_d       = ptr_q;
      data_d      = data_q;
      busy        = state_q != IDLE;
      valid       = state_q == DONE;
      data_out    = data_q;
      reg_rd_en   = 1'b0;
      reg_addr    = '0;
      reg_wr_en   = 1'b0;
      reg_wr_data = '0;
      ram_rd_en   = 1'b0;
      ram_addr    = '0;
      case (state_q)
         IDLE: if (start) begin
            mode_d    = addr_mode_t'(mode);
            operand_d = operand_in;
            state_d   = mode_d == IMM ? DONE : mode_d == DIR ? RAM_REQ : REG_REQ;
            data_d    = mode_d == IMM ? RAM_DATA_WIDTH'(operand_in) : data_q;
         end
         REG_REQ: begin
            reg_rd_en = 1'b1;
            reg_addr  = operand_q[REG_ADDR_WIDTH-1:0];
            state_d   = REG_WAIT;
         end
         REG_WAIT: begin
            data_d  = mode_q == REG ? RAM_DATA_WIDTH'(reg_rd_data) : data_q;
            ptr_d   = mode_q == REG ? ptr_q : RAM_ADDR_WIDTH'(reg_rd_data);
            state_d = mode_q == REG ? DONE : RAM_REQ;
`ifdef OPERAND_FETCH_AUTOINC_EN
            // RAM uses the pointer latched above, i.e. the pre-increment value
            reg_wr_en   = mode_q == INDIR;
            reg_addr    = mode_q == INDIR ? operand_q[REG_ADDR_WIDTH-1:0] : '0;
            reg_wr_data = mode_q == INDIR ? reg_rd_data + REG_DATA_WIDTH'(1) : '0;
`endif
         end
         RAM_REQ: begin
            ram_rd_en = 1'b1;
            ram_addr  = mode_q == DIR ? RAM_ADDR_WIDTH'(operand_q) : ptr_q;
            state_d   = RAM_WAIT;
         end
         RAM_WAIT: begin
            data_d  = ram_rd_data;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: doc/operand_fetch_ctrl.md
# operand_fetch_ctrl

Multi-cycle operand-fetch sequencer for the CISC core. Given an addressing mode and operand field, it drives the synchronous-read register file and RAM, walks through the accesses the mode needs, and returns the fetched operand with a one-cycle `valid` pulse. It sits between instruction decode and the ALU. It replaces combinational operand selection now that register file and RAM both have one-cycle read latency.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, 8, RAM address width
- `RAM_DATA_WIDTH`, 8, RAM data width; also the width of `data_out`
- `REG_ADDR_WIDTH`, 4, register-file address width
- `REG_DATA_WIDTH`, 8, register data width; must equal `RAM_ADDR_WIDTH` because a register holds the pointer in indirect mode
- `OPERAND_WIDTH`, 8, operand field width

Ports:
- `clk` in 1: sole clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a fetch; accepted only in IDLE.
- `mode` in 2: addressing mode; 00 IMM, 01 DIR, 10 INDIR, 11 REG.
- `operand_in` in OPERAND_WIDTH: immediate value, RAM address, or register index (low `REG_ADDR_WIDTH` bits).
- `busy` out 1: high in every state except IDLE.
- `valid` out 1: one-cycle pulse; `data_out` holds the result.
- `data_out` out RAM_DATA_WIDTH: fetched operand; holds its value until the next `valid`.
- `reg_rd_en` out 1: register-file read strobe.
- `reg_addr` out REG_ADDR_WIDTH: register read/write index.
- `reg_rd_data` in REG_DATA_WIDTH: read data, valid the cycle after `reg_rd_en`.
- `reg_wr_en` out 1: register write strobe. Used only by auto-increment (see Configuration).
- `reg_wr_data` out REG_DATA_WIDTH: register write data.
- `ram_rd_en` out 1: RAM read strobe.
- `ram_addr` out RAM_ADDR_WIDTH: RAM read address.
- `ram_rd_data` in RAM_DATA_WIDTH: read data, valid the cycle after `ram_rd_en`.

## Operation
- On reset:
  - All outputs are 0.
  - The FSM goes to IDLE.
  - Latched mode, operand, pointer and `data_out` are cleared.
- IDLE:
  - On `start`, latch `mode` and `operand_in`.
  - Next state: IMM goes to DONE, loading `data_out` with the operand. DIR goes to RAM_REQ. INDIR and REG go to REG_REQ.
- REG_REQ: drive `reg_rd_en=1` and `reg_addr=operand[3:0]`; go to REG_WAIT.
- REG_WAIT:
  - REG: capture `reg_rd_data` into `data_out`; go to DONE.
  - INDIR: capture `reg_rd_data` into the pointer; go to RAM_REQ.
- RAM_REQ: drive `ram_rd_en=1`. Set `ram_addr` to the operand for DIR or to the pointer for INDIR. Go to RAM_WAIT.
- RAM_WAIT: capture `ram_rd_data` into `data_out`; go to DONE.
- DONE: `valid=1`; go to IDLE.
- Strobe outputs:
  - Strobes are combinational from state and are high only in their request state.
  - `reg_addr` and `ram_addr` are 0 whenever their strobe is low.
- `start` while busy is ignored. There is no queueing; a requester must wait for `busy=0`.
- Operand bits above the register index are ignored in REG and INDIR modes.
- Reset mid-fetch aborts immediately. No `valid` is produced and no register write is issued.

## Timing
- Latency from the `start` edge (cycle 0) to the `valid` cycle:
  - IMM: 1
  - REG: 3
  - DIR: 3
  - INDIR: 5
- `busy` rises in cycle 1 and falls in the cycle after `valid`.
- The earliest back-to-back `start` lands in the cycle after `valid`.
- Read data is sampled exactly one cycle after its strobe. No wait states are supported.

## Configuration
- `OPERAND_FETCH_AUTOINC_EN` defined:
  - In INDIR mode, the REG_WAIT cycle also drives `reg_wr_en=1`, `reg_addr=operand[3:0]` and `reg_wr_data=reg_rd_data+1`.
  - The increment wraps modulo 2^REG_DATA_WIDTH (FF becomes 00).
  - The RAM access uses the pre-increment pointer.
- Not defined: `reg_wr_en` and `reg_wr_data` are tied to 0. The ports remain present.

## Structure
- Shared package `cisc_pkg` holds:
  - `addr_mode_t` enum: IMM=2'b00, DIR=2'b01, INDIR=2'b10, REG=2'b11.
  - `fetch_state_t` enum: IDLE, REG_REQ, REG_WAIT, RAM_REQ, RAM_WAIT, DONE.
  - Default width constants.
- No sub-module: a single FSM with its datapath registers.

## Test plan
- IMM with `operand_in=AA` -> `valid` in cycle 1, `data_out=AA`, no strobes asserted.
- DIR with `operand_in=10` and RAM[10]=BB -> `ram_rd_en` in cycle 1 with `ram_addr=10`; `valid` in cycle 3 with `data_out=BB`.
- INDIR with `operand_in=05`, R5=20, RAM[20]=CC -> `reg_addr=5` in cycle 1, `ram_addr=20` in cycle 3, `valid` in cycle 5 with `data_out=CC`. With the macro: a write of R5=21 in cycle 2. With R5=FF, the write is 00.
- REG with `operand_in=F7` and R7=DD -> `reg_addr=7`; `valid` in cycle 3 with `data_out=DD`.
- `start` pulsed during a busy INDIR fetch -> ignored; exactly one `valid`.
- `rst` asserted in cycle 3 of an INDIR fetch -> all outputs 0 next cycle; no `valid`; no write after reset.
